// File: rtl/div_scheduler_if.sv
// Request/response bundle between N requesters and the shared-divider scheduler.
// The scheduler uses the slave modport; requesters and the response sink use master.
interface div_scheduler_if #(
  parameter int N   = 4,
  parameter int M   = 32,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N*M-1:0]        req_dividend;
  logic [N*M-1:0]        req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic signed [M-1:0]   rsp_quotient;
  logic signed [M-1:0]   rsp_remainder;
  logic                  rsp_dbz;
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf
  );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin arbiter sharing one registered signed divider between N requesters.
// Divide-by-zero and -MIN/-1 are answered locally and never reach the divider.
module div_scheduler #(
  parameter int N   = 4,
  parameter int M   = 32,
  parameter int IDW = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  div_scheduler_if.slave      bus,
  output logic signed [M-1:0] div_dividend,
  output logic signed [M-1:0] div_divisor,
  input  logic signed [M-1:0] div_quotient,
  input  logic signed [M-1:0] div_remainder,
  output logic                busy,
  output logic [15:0]         op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic signed [M-1:0] MIN_VAL = {1'b1, {(M-1){1'b0}}};

  state_t              state, state_next;
  logic [IDW-1:0]      ptr, grant_idx, cand, rsp_id_q;
  logic                grant_found, accept, exc_dbz, exc_ovf;
  logic signed [M-1:0] sel_dividend, sel_divisor;
  logic signed [M-1:0] opa, opb, rsp_q, rsp_r;
  logic                rsp_dbz_q, rsp_ovf_q;

  function automatic logic is_dbz(input logic signed [M-1:0] d);
    return d == '0;
  endfunction

  function automatic logic is_ovf(input logic signed [M-1:0] a, input logic signed [M-1:0] d);
    return (a == MIN_VAL) && (d == '1);
  endfunction

  // Search from ptr+1 upward, wrapping, and mux out the winner's operands.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_dividend = bus.req_dividend[i*M +: M];
        sel_divisor  = bus.req_divisor[i*M +: M];
      end
    end
  end

  assign accept  = (state == IDLE) && grant_found;
  assign exc_dbz = is_dbz(sel_divisor);
  assign exc_ovf = is_ovf(sel_dividend, sel_divisor);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready = N'(1) << grant_idx;
          state_next    = (exc_dbz || exc_ovf) ? RESP : ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers only load on normal ops so the divider never sees a zero divisor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= IDW'(N - 1);
      opa       <= '0;
      opb       <= '0;
      rsp_id_q  <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dbz_q <= 1'b0;
      rsp_ovf_q <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        ptr      <= grant_idx;
        rsp_id_q <= grant_idx;
        if (exc_dbz) begin
          rsp_q     <= '0;
          rsp_r     <= sel_dividend;
          rsp_dbz_q <= 1'b1;
          rsp_ovf_q <= 1'b0;
        end else if (exc_ovf) begin
          rsp_q     <= MIN_VAL;
          rsp_r     <= '0;
          rsp_dbz_q <= 1'b0;
          rsp_ovf_q <= 1'b1;
        end else begin
          opa <= sel_dividend;
          opb <= sel_divisor;
        end
      end
      if (state == CAPTURE) begin
        rsp_q     <= div_quotient;
        rsp_r     <= div_remainder;
        rsp_dbz_q <= 1'b0;
        rsp_ovf_q <= 1'b0;
      end
      if (state == RESP && bus.rsp_ready) op_count <= op_count + 16'd1;
    end
  end

  assign div_dividend      = opa;
  assign div_divisor       = opb;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_quotient  = rsp_q;
  assign bus.rsp_remainder = rsp_r;
  assign bus.rsp_dbz       = rsp_dbz_q;
  assign bus.rsp_ovf       = rsp_ovf_q;

endmodule
